// File: rtl/pmem_loader_pkg.sv
// Shared types and defaults for the program-memory loader: FSM states, error codes, size limits.
// ST_CSUM and ERR_CSUM only exist when PMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
package pmem_loader_pkg;

   localparam int unsigned MAX_WORDS_DEF      = 16384;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;
   localparam int          IDLE_W             = 17;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
`ifdef PMEM_LOADER_CHECKSUM_EN
      ST_CSUM = 3'd3,
`endif
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_TIMEOUT = 2'd2
`ifdef PMEM_LOADER_CHECKSUM_EN
      , ERR_CSUM  = 2'd3
`endif
   } err_code_e;

   // States in which the loader is consuming the byte stream.
   function automatic logic is_busy(input state_e s);
      logic b;
      b = 1'b0;
      case (s)
         ST_LEN, ST_DATA: b = 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
         ST_CSUM:         b = 1'b1;
`endif
         default:         b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pmem_loader_asm.sv
// Byte-to-word assembler, little-endian; word_vld pulses the cycle after the fourth byte.
// Accepts one byte per cycle with no stall; word_dat stays stable through the pulse cycle.
`timescale 1ns/1ps
module pmem_loader_asm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] sr_q, sr_d;
   logic        word_vld_q, word_vld_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         sr_q       <= '0;
         word_vld_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         word_vld_q <= word_vld_d;
      end
   end

   // Shifting in from the top leaves the first byte in [7:0] after four bytes.
   always_comb begin
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      word_vld_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         sr_d  = '0;
      end else if (byte_vld) begin
         sr_d       = {byte_dat, sr_q[31:8]};
         cnt_d      = cnt_q + 2'd1;
         word_vld_d = (cnt_q == 2'd3);
      end
   end

   assign word_vld = word_vld_q;
   assign word_dat = sr_q;

endmodule

// File: rtl/pmem_loader.sv
// Program-memory loader: byte stream -> length, N words written to pmem, optional checksum
// (PMEM_LOADER_CHECKSUM_EN); write strobe one cycle after each 4th byte, rx_ready never stalls mid-load.
`timescale 1ns/1ps
module pmem_loader
   import pmem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS      = MAX_WORDS_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        ic1_c_axi_mst_wr_valid,
   output logic [31:0] ic1_axi_mst_wr_addr,
   output logic [31:0] ic1_axi_mst_wr_data,
   output logic        core_hold,
   output logic        done,
   output logic        busy,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int CNT_W = IDX_W + 1;

   state_e            state_q, state_d;
   err_code_e         err_code_q, err_code_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
   logic [31:0]       csum_q, csum_d;
`endif

   logic        busy_w;
   logic        byte_acc;
   logic        asm_clr;
   logic        word_vld;
   logic [31:0] word_dat;
   logic        timeout;
   logic        last_word;

   assign busy_w    = is_busy(state_q);
   assign byte_acc  = rx_valid && busy_w;
   assign timeout   = busy_w && (idle_q >= IDLE_W'(TIMEOUT_CYCLES));
   assign last_word = ({1'b0, idx_q} == (n_q - CNT_W'(1)));

   pmem_loader_asm u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (asm_clr),
      .byte_vld (byte_acc),
      .byte_dat (rx_data),
      .word_vld (word_vld),
      .word_dat (word_dat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         err_code_q <= ERR_NONE;
         n_q        <= '0;
         idx_q      <= '0;
         idle_q     <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         err_code_q <= err_code_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         idle_q     <= idle_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      n_d        = n_q;
      idx_d      = idx_q;
      idle_d     = idle_q;
      asm_clr    = 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      if (busy_w) begin
         if (byte_acc)
            idle_d = '0;
         else if (idle_q != '1)
            idle_d = idle_q + IDLE_W'(1);
      end

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_LEN;
               err_code_d = ERR_NONE;
               n_d        = '0;
               idx_d      = '0;
               idle_d     = '0;
               asm_clr    = 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
               csum_d     = '0;
`endif
            end
         end

         ST_LEN: begin
            if (word_vld) begin
               if (word_dat == 32'd0) begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_DONE;
`endif
               end else if (word_dat > 32'(MAX_WORDS)) begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_LEN;
               end else begin
                  n_d     = CNT_W'(word_dat);
                  state_d = ST_DATA;
               end
            end else if (timeout) begin
               state_d    = ST_ERR;
               err_code_d = ERR_TIMEOUT;
            end
         end

         // The write happens in this cycle; a byte accepted now belongs to the next word.
         ST_DATA: begin
            if (word_vld) begin
               idx_d = idx_q + IDX_W'(1);
`ifdef PMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q + word_dat;
               if (last_word) state_d = ST_CSUM;
`else
               if (last_word) state_d = ST_DONE;
`endif
            end else if (timeout) begin
               state_d    = ST_ERR;
               err_code_d = ERR_TIMEOUT;
            end
         end

`ifdef PMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (word_vld) begin
               if (word_dat == csum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_ERR;
                  err_code_d = ERR_CSUM;
               end
            end else if (timeout) begin
               state_d    = ST_ERR;
               err_code_d = ERR_TIMEOUT;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   // Strobe comes straight from the assembler flop so reset kills it immediately.
   always_comb begin
      rx_ready               = busy_w;
      busy                   = busy_w;
      done                   = (state_q == ST_DONE);
      err                    = (state_q == ST_ERR);
      core_hold              = (state_q != ST_DONE);
      err_code               = err_code_q;
      ic1_c_axi_mst_wr_valid = (state_q == ST_DATA) && word_vld;
      ic1_axi_mst_wr_addr    = 32'(idx_q);
      ic1_axi_mst_wr_data    = word_dat;
   end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench for pmem_loader: table of whole loads plus hand sequences for timeout, reset and restart.
`timescale 1ns/1ps
module tb_pmem_loader;

   localparam int unsigned TB_TO = 64;

   logic        clk, rst_n, start, rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready, wr_valid, core_hold, done, busy, err;
   logic [31:0] wr_addr, wr_data;
   logic [1:0]  err_code;

   int vec_cnt = 0;
   int miss    = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   typedef struct {
      int               id;
      logic [31:0]      len;
      int               nd;
      logic [3:0][31:0] w;
      logic             exp_done;
      logic [1:0]       exp_code;
   } vec_t;

   vec_t tbl[6];

   pmem_loader #(.TIMEOUT_CYCLES(TB_TO)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .start                  (start),
      .rx_valid               (rx_valid),
      .rx_data                (rx_data),
      .rx_ready               (rx_ready),
      .ic1_c_axi_mst_wr_valid (wr_valid),
      .ic1_axi_mst_wr_addr    (wr_addr),
      .ic1_axi_mst_wr_data    (wr_data),
      .core_hold              (core_hold),
      .done                   (done),
      .busy                   (busy),
      .err                    (err),
      .err_code               (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
   end

   function automatic vec_t mk(input int id, input logic [31:0] len, input int nd,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic dn, input logic [1:0] code);
      vec_t v;
      v.id = id; v.len = len; v.nd = nd;
      v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = 32'd0;
      v.exp_done = dn; v.exp_code = code;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!rx_ready) begin
         miss++;
         $display("FAIL rx_ready_wait: rx_ready=%b, expected 1", rx_ready);
      end
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end();
      int t;
      t = 0;
      while (!(done || err) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("end_reached", {31'd0, done | err}, 32'd1);
   endtask

   task automatic chk_writes(input string tag, input int n, input logic [3:0][31:0] w);
      chk({tag, "_wr_count"}, 32'(wa.size()), 32'(n));
      for (int i = 0; i < n && i < wa.size(); i++) begin
         chk($sformatf("%s_wr%0d_addr", tag, i), wa[i], 32'(i));
         chk($sformatf("%s_wr%0d_data", tag, i), wd[i], w[i]);
      end
   endtask

   task automatic send_sum(input int n, input logic [3:0][31:0] w);
`ifdef PMEM_LOADER_CHECKSUM_EN
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < n; i++) s = s + w[i];
      send_word(s);
`else
      if (n < 0) $display("send_sum: negative count %0d, %h", n, w);
`endif
   endtask

   task automatic run_vec(input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", v.id);
      wa.delete(); wd.delete();
      pulse_start();
      send_word(v.len);
      for (int i = 0; i < v.nd; i++) send_word(v.w[i]);
      if (v.exp_done) send_sum(v.nd, v.w);
      wait_end();
      chk({tag, "_done"},      {31'd0, done},      {31'd0, v.exp_done});
      chk({tag, "_err"},       {31'd0, err},       {31'd0, !v.exp_done});
      chk({tag, "_err_code"},  {30'd0, err_code},  {30'd0, v.exp_code});
      chk({tag, "_core_hold"}, {31'd0, core_hold}, {31'd0, !v.exp_done});
      chk({tag, "_busy"},      {31'd0, busy},      32'd0);
      chk_writes(tag, v.exp_done ? v.nd : 0, v.w);
   endtask

   initial begin
      logic [3:0][31:0] w3;
      rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

      tbl[0] = mk(0, 32'd2,          2, 32'h0000_0013, 32'h0000_006F, 32'h0,          1'b1, 2'd0);
      tbl[1] = mk(1, 32'h0000_4001,  0, 32'h0,         32'h0,         32'h0,          1'b0, 2'd1);
      tbl[2] = mk(2, 32'd0,          0, 32'h0,         32'h0,         32'h0,          1'b1, 2'd0);
      tbl[3] = mk(3, 32'd3,          3, 32'hA5A5_A5A5, 32'h1234_5678, 32'h8000_0001,  1'b1, 2'd0);
      tbl[4] = mk(4, 32'hFFFF_FFFF,  0, 32'h0,         32'h0,         32'h0,          1'b0, 2'd1);
      tbl[5] = mk(5, 32'd1,          1, 32'hDEAD_BEEF, 32'h0,         32'h0,          1'b1, 2'd0);

      // Reset values
      #12;
      chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
      chk("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
      chk("rst_wr_valid",  {31'd0, wr_valid},  32'd0);
      chk("rst_flags",     {29'd0, done, busy, err}, 32'd0);
      chk("rst_err_code",  {30'd0, err_code},  32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_vec(tbl[i]);

      // Timeout after a partial word: no write, err_code 2, not earlier than the limit
      wa.delete(); wd.delete();
      pulse_start();
      send_word(32'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (TB_TO - 4) begin @(posedge clk); #1; end
      chk("to_not_early", {31'd0, err}, 32'd0);
      wait_end();
      chk("to_err",      {31'd0, err},      32'd1);
      chk("to_err_code", {30'd0, err_code}, 32'd2);
      chk("to_wr_count", 32'(wa.size()),    32'd0);

      // Start pulse during DATA must be ignored
      wa.delete(); wd.delete();
      w3 = '0;
      w3[0] = 32'h0102_0304; w3[1] = 32'hCAFE_F00D; w3[2] = 32'h0000_00FF;
      pulse_start();
      send_word(32'd3);
      fork
         begin
            for (int i = 0; i < 3; i++) send_word(w3[i]);
         end
         begin
            repeat (6) begin @(posedge clk); end
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
      join
      send_sum(3, w3);
      wait_end();
      chk("ign_done", {31'd0, done}, 32'd1);
      chk_writes("ign", 3, w3);

      // Reset in the middle of a 5-word load, during the third write strobe
      wa.delete(); wd.delete();
      pulse_start();
      send_word(32'd5);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      send_word(32'h3333_3333);
      chk("mid_wr_valid_pre", {31'd0, wr_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_wr_valid_rst", {31'd0, wr_valid},  32'd0);
      chk("mid_core_hold",    {31'd0, core_hold}, 32'd1);
      chk("mid_busy",         {31'd0, busy},      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mid_wr_count", 32'(wa.size()), 32'd2);
      wa.delete(); wd.delete();
      w3 = '0;
      w3[0] = 32'h0000_0011;
      pulse_start();
      send_word(32'd1);
      send_word(w3[0]);
      send_sum(1, w3);
      wait_end();
      chk("reload_done", {31'd0, done}, 32'd1);
      chk_writes("reload", 1, w3);

`ifdef PMEM_LOADER_CHECKSUM_EN
      // Checksum wraps mod 2^32: good value -> done, bad value -> err_code 3
      pulse_start();
      send_word(32'd2);
      send_word(32'hFFFF_FFFF);
      send_word(32'h0000_0002);
      send_word(32'h0000_0001);
      wait_end();
      chk("csum_ok_done", {31'd0, done}, 32'd1);
      pulse_start();
      send_word(32'd2);
      send_word(32'hFFFF_FFFF);
      send_word(32'h0000_0002);
      send_word(32'h0000_0002);
      wait_end();
      chk("csum_bad_err",  {31'd0, err},      32'd1);
      chk("csum_bad_code", {30'd0, err_code}, 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
      $finish;
   end

endmodule

// File: doc/pmem_loader.md
PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 Parameter MAX_WORDS, 16384, largest accepted program length in 32-bit words.
REQ-002 Parameter TIMEOUT_CYCLES, 65535, maximum idle cycles between accepted bytes while loading.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  one-cycle request to begin a load.
REQ-006 Port rx_valid  input  1  byte-stream valid.
REQ-007 Port rx_data  input  8  byte-stream payload.
REQ-008 Port rx_ready  output  1  byte accepted when rx_valid && rx_ready.
REQ-009 Port ic1_c_axi_mst_wr_valid  output  1  one-cycle program-memory write strobe.
REQ-010 Port ic1_axi_mst_wr_addr  output  32  word index; bits [31:14] zero.
REQ-011 Port ic1_axi_mst_wr_data  output  32  instruction word.
REQ-012 Port core_hold  output  1  holds the core in reset while the image is invalid.
REQ-013 Port done / busy / err  output  1 each  load complete / load in progress / load failed.
REQ-014 Port err_code  output  2  0 none, 1 length, 2 timeout, 3 checksum.

Function
REQ-015 States SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-016 IDLE/DONE/ERR + start SHALL go to LEN, clear counters, err, err_code, done; start in LEN/DATA/CSUM SHALL be ignored.
REQ-017 rx_ready SHALL be 1 exactly in LEN, DATA, CSUM; busy SHALL equal rx_ready.
REQ-018 Bytes SHALL assemble little-endian: first accepted byte into bits [7:0], fourth into [31:24].
REQ-019 LEN SHALL collect a 32-bit word count N; N==0 SHALL go to CSUM (macro on) or DONE (off); N>MAX_WORDS SHALL go to ERR with err_code 1; else DATA.
REQ-020 In DATA, the cycle after each fourth byte is accepted, ic1_c_axi_mst_wr_valid SHALL be 1 for exactly one cycle with addr = word index (0..N-1) and the assembled data.
REQ-021 rx_ready SHALL stay 1 during the write cycle; a byte accepted that cycle starts the next word.
REQ-022 After write N-1 the FSM SHALL enter CSUM (macro on) or DONE (off) in the write cycle.
REQ-023 A 17-bit idle counter SHALL reset on each accepted byte and on entry to LEN; reaching TIMEOUT_CYCLES in LEN/DATA/CSUM SHALL enter ERR with err_code 2.
REQ-024 core_hold SHALL be 1 in every state except DONE; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-025 Partial words at error or restart SHALL be discarded and never written.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all outputs 0 except core_hold = 1, counters and assembly register cleared.
REQ-027 Reset mid-load SHALL deassert ic1_c_axi_mst_wr_valid asynchronously; no write completes.

Configuration
REQ-028 Macro PMEM_LOADER_CHECKSUM_EN compiled in: after N words a 32-bit checksum word SHALL be received in CSUM; it SHALL equal the mod-2^32 sum of all data words, match to DONE, mismatch to ERR with err_code 3.
REQ-029 Macro absent: CSUM state, checksum accumulator and err_code 3 SHALL not exist; last write SHALL lead directly to DONE.

Structure
REQ-030 Package pmem_loader_pkg SHALL hold the state enum, err_code enum, and MAX_WORDS/TIMEOUT_CYCLES defaults.
REQ-031 Sub-module pmem_loader_asm SHALL implement the byte-to-word assembler (byte counter, shift register, word_valid pulse); the FSM stays in pmem_loader.

Verification
REQ-032 start, bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 (macro off) -> writes addr 0 data 0x00000013, addr 1 data 0x0000006F, then done=1, core_hold=0.
REQ-033 Length bytes 01 40 00 00 (N=16385) -> err=1, err_code=1, no write strobe, core_hold=1.
REQ-034 N=1, two data bytes then TIMEOUT_CYCLES idle cycles -> err_code=2, no write issued.
REQ-035 Macro on, N=2 words 0xFFFFFFFF, 0x00000002, checksum 0x00000001 -> done=1; checksum 0x00000002 -> err_code=3.
REQ-036 rst_n low after 3 of 5 words -> wr_valid 0 at once, IDLE, core_hold=1; new start reloads from addr 0.
REQ-037 start pulsed during DATA -> ignored; writes continue without gap or duplicate.
